bip_debug_tx: RTL
=================

Name: bip_debug_tx

Overview:
- Debug/report stage downstream of the BIP processor core.
- Counts clock cycles while the CPU runs. On the rising edge of the CPU halt signal, snapshots the program counter, accumulator and cycle count.
- Serializes the snapshot as a fixed 7-byte UART 8N1 frame to a host PC.
- Sits beside the control/datapath at the top level and consumes their state. It has no feedback into the CPU.

Parameters:
- BAUD_DIV, 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range is 2 or more.
- PC_W, 11, program counter width.
- DATA_W, 16, accumulator width.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- halt  in  1  level; high while the CPU is halted (HLT decoded).
- pc  in  PC_W  current program counter.
- acc  in  DATA_W  current accumulator value.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high from snapshot capture until the stop bit of the last byte ends.
- frame_done  out  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (rst low, asynchronous):
  - tx=1, busy=0, frame_done=0.
  - FSM in IDLE; cycle counter=0; halt edge register=1, so a halt already high at reset release does not trigger a report.
  - Snapshot registers=0; baud counter=0; bit index=0; byte index=0.
- Cycle counter: increments by 1 on every clk while halt==0. It saturates at 2^CNT_W-1 and does not wrap. It is not cleared by halt; only reset clears it.
- Halt edge detection: halt_q registers halt; rise = halt & ~halt_q.
- Rise while busy==0: in that cycle, latch pc, acc and the counter (pre-increment value) into snapshot registers. busy=1 from the next cycle. FSM goes to START, with byte index=0.
- Rise while busy==1: ignored; no queueing.
- Frame byte order:
  1. 0xA5 (sync)
  2. {5'b0, pc[10:8]}
  3. pc[7:0]
  4. acc[15:8]
  5. acc[7:0]
  6. cnt[15:8]
  7. cnt[7:0]
- Zero-extend each field to a byte boundary, MSB byte first.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit holds for exactly BAUD_DIV cycles.
- FSM states:
  - IDLE -> START on accepted rise.
  - START -> DATA after BAUD_DIV cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) after BAUD_DIV cycles, or -> IDLE if byte index==6.
  - No idle gap between bytes.
- Latency: rise sampled at edge N; tx goes low at edge N+1. The full frame occupies 70*BAUD_DIV cycles. busy falls, and frame_done pulses high for one cycle, at edge N+1+70*BAUD_DIV, which is also the cycle STOP -> IDLE.
- halt falling mid-frame: the frame completes unchanged from the snapshot. Counting resumes immediately.
- halt pulsing again during busy: no second frame. A new rise after busy==0 produces a new frame with the updated counter.
- rst asserted mid-frame: tx returns to 1 immediately (asynchronous) and the frame is abandoned.
- tx is driven from a register (glitch-free).

Decomposition:
- Shared package bip_debug_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP)
  - SYNC_BYTE=8'hA5
  - FRAME_BYTES=7
  - the default BAUD_DIV
- One sub-module is natural: uart_tx_byte.
  - Inputs: clk, rst, start, data[7:0].
  - Outputs: tx, done (one-cycle pulse at end of stop bit).
  - It owns the baud counter and bit shifter.
- The top-level holds the edge detector, cycle counter, snapshot registers and the byte sequencer.

Test Plan:
- BAUD_DIV=4. Release rst, keep halt=0 for 10 cycles, then set pc=11'h123, acc=16'hBEEF, halt=1 -> the decoded frame is A5 01 23 BE EF 00 0A. tx goes low 1 cycle after the rise. busy falls and frame_done pulses exactly 280 cycles after the first start-bit edge.
- halt held high through reset release -> no frame; tx stays 1 and busy stays 0 for 500 cycles.
- During busy, toggle halt 0->1 twice -> exactly one frame. After busy falls, a new rise gives a frame whose count is 10 plus the cycles spent with halt low.
- Force the counter near saturation (CNT_W=4, run 20 cycles) -> count field reads 0x000F and does not wrap.
- Assert rst at cycle 37 of a frame -> tx=1 in the same cycle without waiting for clk; busy=0; counter=0. The next halt rise produces a clean full frame.
- Check the bit period by sampling at bit centers with BAUD_DIV=5 (odd) -> all 7 bytes decode correctly and every stop bit =1.

Source files
------------

// File: rtl/bip_debug_pkg.sv
// Shared definitions for the BIP debug report transmitter.
// Latency: n/a (types, constants and a pure frame-byte selector).
// Backpressure: n/a.
package bip_debug_pkg;

    // Bit-phase encoding of the UART byte transmitter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         FRAME_BYTES  = 7;
    localparam int         BAUD_DIV_DEF = 5208;   // 50 MHz / 9600 baud

    // Report frame layout, MSB byte first for every field:
    // sync, pc[15:8], pc[7:0], acc[15:8], acc[7:0], cnt[15:8], cnt[7:0].
    // Fields arrive already zero-extended to 16 bits.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [15:0] pc16,
                                              input logic [15:0] acc16,
                                              input logic [15:0] cnt16);
        logic [7:0] b;
        b = SYNC_BYTE;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = pc16[15:8];
            3'd2:    b = pc16[7:0];
            3'd3:    b = acc16[15:8];
            3'd4:    b = acc16[7:0];
            3'd5:    b = cnt16[15:8];
            default: b = cnt16[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bip_debug_tx_if.sv
// CPU-state tap and UART report outputs of the debug transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: none; the report path never stalls the CPU.
// Signals: halt/pc/acc come from the CPU side, tx/busy/frame_done go out.
interface bip_debug_tx_if #(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16
);
    logic              halt;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic              tx;
    logic              busy;
    logic              frame_done;

    modport master (output halt, pc, acc, input  tx, busy, frame_done);
    modport slave  (input  halt, pc, acc, output tx, busy, frame_done);
endinterface

// File: rtl/bip_debug_tx_uart_tx_byte.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// Latency: tx drops on the edge that samples start; each bit lasts BAUD_DIV cycles.
// Backpressure: start is honoured only when idle or in the last stop-bit cycle.
// Ports: clk, rst (async active-low), start, data[7:0] in; tx, done out.
// done is high during the final cycle of the stop bit, so a start presented
// in that same cycle chains the next byte with no idle gap on the line.
module uart_tx_byte
    import bip_debug_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    tx_state_t     r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = (r_baud == CW'(BAUD_DIV - 1));
    assign done      = (r_state == STOP) && w_bit_end;
    assign tx        = r_tx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= START;
                        r_shift <= data;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (start) begin
                            r_state <= START;
                            r_shift <= data;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/bip_debug_tx.sv
// Snapshots pc/acc/run-cycle count on a CPU halt rise and sends a 7-byte UART report.
// Latency: rise seen at edge N, start bit at edge N+1, busy falls at N+1+70*BAUD_DIV.
// Backpressure: none; halt rises while a report is in flight are dropped, not queued.
// Ports: clk, rst (async active-low); dbg_if.slave carries halt/pc/acc in and
// tx/busy/frame_done out. frame_done is high for the one cycle after busy falls.
module bip_debug_tx
    import bip_debug_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int PC_W     = 11,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    bip_debug_tx_if.slave  dbg_if
);
    logic              r_halt_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_snap_pc;
    logic [15:0]       r_snap_acc;
    logic [15:0]       r_snap_cnt;
    logic              r_busy;
    logic              r_kick;
    logic              r_frame_done;
    logic [2:0]        r_byte_idx;

    logic [PC_W-1:0]   w_pc;
    logic [DATA_W-1:0] w_acc;
    logic              w_rise;
    logic              w_accept;
    logic              w_byte_done;
    logic              w_last;
    logic              w_next;
    logic              w_start;
    logic [2:0]        w_sel;
    logic [7:0]        w_byte;
    logic              w_tx;

    assign w_pc     = dbg_if.pc;
    assign w_acc    = dbg_if.acc;
    assign w_rise   = dbg_if.halt & ~r_halt_q;
    assign w_accept = w_rise & ~r_busy;
    assign w_last   = (r_byte_idx == 3'(FRAME_BYTES - 1));

    // The first byte is kicked one cycle after capture; later bytes are
    // presented combinationally in the last stop-bit cycle of the previous
    // byte so the serializer chains them back to back.
    assign w_next  = w_byte_done & r_busy & ~w_last;
    assign w_start = r_kick | w_next;
    assign w_sel   = w_next ? (r_byte_idx + 3'd1) : r_byte_idx;
    assign w_byte  = frame_byte(w_sel, r_snap_pc, r_snap_acc, r_snap_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Edge register starts high so a halt already asserted at reset
            // release is not mistaken for a fresh halt.
            r_halt_q     <= 1'b1;
            r_cnt        <= '0;
            r_snap_pc    <= '0;
            r_snap_acc   <= '0;
            r_snap_cnt   <= '0;
            r_busy       <= 1'b0;
            r_kick       <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte_idx   <= '0;
        end else begin
            r_halt_q     <= dbg_if.halt;
            r_kick       <= w_accept;
            r_frame_done <= 1'b0;

            // Run-cycle counter saturates instead of wrapping.
            if (!dbg_if.halt && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_snap_pc  <= 16'(w_pc);
                r_snap_acc <= 16'(w_acc);
                r_snap_cnt <= 16'(r_cnt);
                r_busy     <= 1'b1;
                r_byte_idx <= '0;
            end else if (w_byte_done && r_busy) begin
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .data  (w_byte),
        .tx    (w_tx),
        .done  (w_byte_done)
    );

    assign dbg_if.tx         = w_tx;
    assign dbg_if.busy       = r_busy;
    assign dbg_if.frame_done = r_frame_done;

endmodule
